arbiter_rr_stream: RTL and testbench
====================================

# arbiter_rr_stream

Parametrised round-robin successor to the output-stationary cached arbiter. It grants main-memory access to one of NUM_CORES PE cores at a time. Per-transfer burst lengths and base addresses come from a config FIFO. The memory side uses valid/ready command and beat handshakes with backpressure, so no tristated buses are needed. It sits between the PE array cores and the main-memory controller.

## Interface
- MAIN_MEM_ADDR_WIDTH, 32, main memory address width
- NUM_CORES, 4, number of PE cores (>=2)
- BURST_WIDTH, 6, burst length field width; a burst is 0..2^BURST_WIDTH-1 beats
- NUM_READ_STAGES, 3, bursts per core load (config, weights, acts order); 1..4
- w_clock  in  1  clock, all state on rising edge
- w_reset_n  in  1  asynchronous active-low reset
- w_req  in  NUM_CORES  per-core request level
- w_grant  out  NUM_CORES  one-hot grant, held for the whole transaction
- w_load  out  NUM_CORES  per-core state: 0 = core needs load (read), 1 = holds psums (write)
- w_cfg_valid  in  1  config FIFO entry valid
- w_cfg_ready  out  1  config entry consumed this cycle when both high
- w_cfg_addr  in  MAIN_MEM_ADDR_WIDTH  base address of next burst
- w_cfg_burst  in  BURST_WIDTH  beat count of next burst
- w_cmd_valid  out  1  burst command valid
- w_cmd_ready  in  1  memory accepts command
- w_cmd_rw  out  1  1 = read (core load), 0 = write (psum unload)
- w_cmd_burst  out  BURST_WIDTH  beat count of command
- w_addr_valid  out  1  beat address valid
- w_addr  out  MAIN_MEM_ADDR_WIDTH  beat address
- w_mem_ready  in  1  memory accepts beat
- w_stage  out  2  current stage index within transaction
- w_done  out  1  one-cycle pulse at transaction end

## Operation
- States: IDLE, ARB, CFG, CMD, BEAT, DONE.
- IDLE: all handshake outputs low. Move to ARB when w_req != 0.
- ARB (1 cycle): sel = first requesting core at index >= r_ptr, scanning upward modulo NUM_CORES. Register sel and set w_grant[sel]. Mode is read if w_load[sel]==0, else write. Stage count is NUM_READ_STAGES for read and 1 for write. Stage resets to 0. If w_req is all-zero here (request dropped), return to IDLE with no grant.
- CFG: w_cfg_ready=1. On handshake, capture addr/burst. If burst==0 the stage is skipped and the entry is still consumed: advance stage, or go to DONE if it was the last stage. Otherwise go to CMD.
- CMD: w_cmd_valid=1 with rw/burst/addr stable until w_cmd_ready. Then go to BEAT with beat count 0.
- BEAT: w_addr_valid=1, w_addr = base + count, mod 2^MAIN_MEM_ADDR_WIDTH (wraps silently). Count increments on w_mem_ready. On the accepted beat with count == burst-1: if more stages remain, go to CFG with stage+1; otherwise go to DONE.
- DONE (1 cycle): w_done=1. w_grant cleared. w_load[sel] toggles. r_ptr = (sel+1) mod NUM_CORES. Next state is ARB if w_req has any bit other than sel set, else IDLE. The granted core must drop w_req in the cycle after w_done; a still-high request of sel is treated as a new request for the opposite mode.
- w_req is ignored outside IDLE/ARB/DONE; a core's request only matters when sampled.

## Timing
- Reset (async assert, sync release): state IDLE, r_ptr=0, w_load=0, w_grant=0, w_cfg_ready=0, w_cmd_valid=0, w_cmd_rw=0, w_cmd_burst=0, w_addr_valid=0, w_addr=0, w_stage=0, w_done=0. Reset mid-burst aborts immediately; no beat or entry completes after assertion.
- w_req high at edge N in IDLE: ARB at N+1, w_grant valid from edge N+2 (CFG).
- Earliest cfg accept is the first CFG cycle. Earliest command accept is the cycle after. Beats start the cycle after command accept, one per cycle when w_mem_ready is held high.
- Minimum single-stage write with burst B and all ready signals high: IDLE->done = 1 (ARB) + 1 (CFG) + 1 (CMD) + B (BEAT) + 1 (DONE).
- All outputs are registered or decoded from the registered state; there is no combinational path from inputs to outputs.
- Handshake outputs hold their values while the corresponding ready is low.

## Test plan
- Single read: core 0 req, FIFO holds {0x100,4},{0x200,2},{0x300,3}, all ready high -> three commands rw=1, addresses 0x100-0x103, 0x200-0x201, 0x300-0x302, w_done once, w_load[0]=1.
- Follow-up write: core 0 req again, FIFO {0x400,5} -> one command rw=0 burst 5, addresses 0x400-0x404, w_load[0]=0.
- Round robin: w_req=4'b1111 held, each core toggles req per protocol -> grant order 0,1,2,3,0; no core granted twice while another waits.
- Backpressure: w_cmd_ready low 3 cycles, w_mem_ready toggling every cycle, FIFO empty 2 cycles -> outputs held stable; beat count and addresses are exact with no duplicates or skips.
- Boundaries: burst=0 stage skipped with entry consumed; base 0xFFFFFFFE burst 4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
- Reset mid-BEAT at beat 2 of 8 -> all outputs at reset values asynchronously; after release, IDLE and w_load all 0.

Source files
------------

// File: rtl/arbiter_rr_stream.sv
// arbiter_rr_stream
//   Round-robin arbiter that grants main-memory access to one of NUM_CORES
//   PE cores at a time. A granted core is either loaded (read, NUM_READ_STAGES
//   bursts: config, weights, acts) or unloaded (write, one psum burst),
//   alternating per core. Burst base/length come from a config FIFO; the
//   memory side issues one command per burst followed by one address beat
//   per cycle of acceptance.
//
// Handshakes: every valid/ready pair transfers on a rising edge where both
//   are high. Valid-side outputs (w_cmd_*, w_addr_valid/w_addr) are decoded
//   from registered state and therefore hold steady while ready is low.
//
// Ports:
//   w_clock, w_reset_n          clock, asynchronous active-low reset
//   w_req   [NUM_CORES]         per-core request level
//   w_grant [NUM_CORES]         one-hot grant for the whole transaction
//   w_load  [NUM_CORES]         0 = core needs load, 1 = core holds psums
//   w_cfg_valid/ready/addr/burst config FIFO read side
//   w_cmd_valid/ready/rw/burst  burst command (rw 1 = read)
//   w_addr_valid/w_addr/w_mem_ready  per-beat address handshake
//   w_stage                     stage index within the transaction
//   w_done                      one-cycle pulse at transaction end
//   w_state_dbg                 current FSM state for observation
module arbiter_rr_stream #(
  parameter int MAIN_MEM_ADDR_WIDTH = 32,
  parameter int NUM_CORES           = 4,
  parameter int BURST_WIDTH         = 6,
  parameter int NUM_READ_STAGES     = 3
) (
  input  logic                           w_clock,
  input  logic                           w_reset_n,
  input  logic [NUM_CORES-1:0]           w_req,
  output logic [NUM_CORES-1:0]           w_grant,
  output logic [NUM_CORES-1:0]           w_load,
  input  logic                           w_cfg_valid,
  output logic                           w_cfg_ready,
  input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_cfg_addr,
  input  logic [BURST_WIDTH-1:0]         w_cfg_burst,
  output logic                           w_cmd_valid,
  input  logic                           w_cmd_ready,
  output logic                           w_cmd_rw,
  output logic [BURST_WIDTH-1:0]         w_cmd_burst,
  output logic                           w_addr_valid,
  output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_addr,
  input  logic                           w_mem_ready,
  output logic [1:0]                     w_stage,
  output logic                           w_done,
  output logic [2:0]                     w_state_dbg
);

  localparam int SEL_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARB  = 3'd1,
    S_CFG  = 3'd2,
    S_CMD  = 3'd3,
    S_BEAT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                         r_state;
  state_t                         n_state;
  logic [SEL_W-1:0]               r_ptr;
  logic [SEL_W-1:0]               r_sel;
  logic [NUM_CORES-1:0]           r_grant;
  logic [NUM_CORES-1:0]           r_load;
  logic                           r_rw;
  logic [1:0]                     r_stage;
  logic [MAIN_MEM_ADDR_WIDTH-1:0] r_base;
  logic [BURST_WIDTH-1:0]         r_burst;
  logic [BURST_WIDTH-1:0]         r_count;

  logic [SEL_W-1:0]               arb_sel;
  logic [SEL_W-1:0]               arb_idx;
  logic                           arb_found;
  logic                           is_last;
  logic                           beat_last;

  // Rotating priority: first requester at or above r_ptr, wrapping around.
  always_comb begin
    arb_sel   = r_ptr;
    arb_idx   = '0;
    arb_found = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      arb_idx = SEL_W'((int'(r_ptr) + i) % NUM_CORES);
      if (!arb_found && w_req[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  // Reads walk all load stages, writes have a single psum stage.
  assign is_last   = r_rw ? (r_stage == 2'(NUM_READ_STAGES - 1)) : (r_stage == 2'd0);
  assign beat_last = (r_count == r_burst - 1'b1);

  always_comb begin
    n_state = r_state;
    case (r_state)
      S_IDLE: if (|w_req) n_state = S_ARB;
      S_ARB:  n_state = arb_found ? S_CFG : S_IDLE;
      S_CFG: begin
        if (w_cfg_valid) begin
          if (w_cfg_burst != '0) n_state = S_CMD;
          else if (is_last)      n_state = S_DONE;
        end
      end
      S_CMD:  if (w_cmd_ready) n_state = S_BEAT;
      S_BEAT: if (w_mem_ready && beat_last) n_state = is_last ? S_DONE : S_CFG;
      // The finishing core's own request is not a reason to re-arbitrate.
      S_DONE: n_state = (|(w_req & ~r_grant)) ? S_ARB : S_IDLE;
      default: n_state = S_IDLE;
    endcase
  end

  always_ff @(posedge w_clock or negedge w_reset_n) begin
    if (!w_reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_load  <= '0;
      r_rw    <= 1'b0;
      r_stage <= '0;
      r_base  <= '0;
      r_burst <= '0;
      r_count <= '0;
    end else begin
      r_state <= n_state;
      case (r_state)
        S_ARB: begin
          if (arb_found) begin
            r_sel   <= arb_sel;
            r_grant <= {{(NUM_CORES-1){1'b0}}, 1'b1} << arb_sel;
            r_rw    <= ~r_load[arb_sel];
            r_stage <= '0;
          end
        end
        S_CFG: begin
          if (w_cfg_valid) begin
            r_base  <= w_cfg_addr;
            r_burst <= w_cfg_burst;
            r_count <= '0;
            // Zero-length entry: consume it and move straight to the next stage.
            if (w_cfg_burst == '0 && !is_last) r_stage <= r_stage + 1'b1;
          end
        end
        S_BEAT: begin
          if (w_mem_ready) begin
            if (!beat_last)    r_count <= r_count + 1'b1;
            else if (!is_last) r_stage <= r_stage + 1'b1;
          end
        end
        S_DONE: begin
          r_grant        <= '0;
          r_load[r_sel]  <= ~r_load[r_sel];
          r_ptr          <= (r_sel == SEL_W'(NUM_CORES - 1)) ? '0 : r_sel + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign w_grant      = r_grant;
  assign w_load       = r_load;
  assign w_cfg_ready  = (r_state == S_CFG);
  assign w_cmd_valid  = (r_state == S_CMD);
  assign w_cmd_rw     = r_rw;
  assign w_cmd_burst  = r_burst;
  assign w_addr_valid = (r_state == S_BEAT);
  // Address wraps modulo 2^MAIN_MEM_ADDR_WIDTH by plain truncation.
  assign w_addr       = r_base + MAIN_MEM_ADDR_WIDTH'(r_count);
  assign w_stage      = r_stage;
  assign w_done       = (r_state == S_DONE);
  assign w_state_dbg  = r_state;

endmodule

// File: tb/tb_arbiter_rr_stream.sv
// Testbench for arbiter_rr_stream: transaction-level reference model
// (round-robin choice, per-core mode, expected commands/beats queues).
module tb_arbiter_rr_stream;
  localparam int AW  = 32;
  localparam int NC  = 4;
  localparam int BW  = 6;
  localparam int NRS = 3;

  logic          w_clock = 1'b0;
  logic          w_reset_n = 1'b1;
  logic [NC-1:0] w_req = '0;
  logic [NC-1:0] w_grant;
  logic [NC-1:0] w_load;
  logic          w_cfg_valid = 1'b0;
  logic          w_cfg_ready;
  logic [AW-1:0] w_cfg_addr = '0;
  logic [BW-1:0] w_cfg_burst = '0;
  logic          w_cmd_valid;
  logic          w_cmd_ready = 1'b1;
  logic          w_cmd_rw;
  logic [BW-1:0] w_cmd_burst;
  logic          w_addr_valid;
  logic [AW-1:0] w_addr;
  logic          w_mem_ready = 1'b1;
  logic [1:0]    w_stage;
  logic          w_done;
  logic [2:0]    w_state_dbg;

  arbiter_rr_stream #(
    .MAIN_MEM_ADDR_WIDTH(AW), .NUM_CORES(NC), .BURST_WIDTH(BW), .NUM_READ_STAGES(NRS)
  ) dut (
    .w_clock(w_clock), .w_reset_n(w_reset_n), .w_req(w_req), .w_grant(w_grant),
    .w_load(w_load), .w_cfg_valid(w_cfg_valid), .w_cfg_ready(w_cfg_ready),
    .w_cfg_addr(w_cfg_addr), .w_cfg_burst(w_cfg_burst), .w_cmd_valid(w_cmd_valid),
    .w_cmd_ready(w_cmd_ready), .w_cmd_rw(w_cmd_rw), .w_cmd_burst(w_cmd_burst),
    .w_addr_valid(w_addr_valid), .w_addr(w_addr), .w_mem_ready(w_mem_ready),
    .w_stage(w_stage), .w_done(w_done), .w_state_dbg(w_state_dbg)
  );

  // ---------------- clock ----------------
  initial forever #5 w_clock = ~w_clock;

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_err = 0;

  logic [39:0]   cfg_q[$];       // {stage, burst, addr} fed to the config FIFO
  logic [38:0]   exp_q[$];       // expected commands {rw, burst, addr}
  logic [AW-1:0] exp_beat_q[$];  // expected beat addresses
  logic [NC-1:0] grant_log[$];

  logic [NC-1:0] m_load = '0;
  int            m_ptr = 0;
  int            m_sel = 0;
  int            n_txn = 0;
  logic [NC-1:0] exp_grant = '0;
  logic [NC-1:0] obs_grant = '0;
  logic [AW-1:0] g_addr[4];
  logic [BW-1:0] g_burst[4];
  int            bp_mode = 0;
  int            done_cnt = 0;
  int            beat_cnt = 0;
  int            last_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic report_and_finish();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  endtask

  // ---------------- monitor (samples mid-cycle) ----------------
  bit            cmd_stall = 0;
  bit            beat_stall = 0;
  logic [38:0]   held_cmd;
  logic [AW-1:0] held_addr;

  always @(negedge w_clock) begin
    logic [39:0]   hd;
    logic [38:0]   ec;
    logic [AW-1:0] eb;
    if (!w_reset_n) begin
      cmd_stall  = 0;
      beat_stall = 0;
    end else begin
      if (cmd_stall) begin
        check_eq("cmd_hold_valid", 64'(w_cmd_valid), 64'd1);
        check_eq("cmd_hold_fields", 64'({w_cmd_rw, w_cmd_burst, w_addr}), 64'(held_cmd));
      end
      if (beat_stall) begin
        check_eq("beat_hold_valid", 64'(w_addr_valid), 64'd1);
        check_eq("beat_hold_addr", 64'(w_addr), 64'(held_addr));
      end
      cmd_stall  = w_cmd_valid && !w_cmd_ready;
      held_cmd   = {w_cmd_rw, w_cmd_burst, w_addr};
      beat_stall = w_addr_valid && !w_mem_ready;
      held_addr  = w_addr;
      if (w_cfg_valid && w_cfg_ready && cfg_q.size() != 0) begin
        hd = cfg_q.pop_front();
        check_eq("cfg_stage", 64'(w_stage), 64'(hd[39:38]));
        check_eq("cfg_grant", 64'(w_grant), 64'(exp_grant));
        obs_grant = w_grant;
      end
      if (w_cmd_valid && w_cmd_ready) begin
        if (exp_q.size() == 0) check_eq("cmd_extra", 64'(exp_q.size()), 64'd1);
        else begin
          ec = exp_q.pop_front();
          check_eq("cmd", 64'({w_cmd_rw, w_cmd_burst, w_addr}), 64'(ec));
          check_eq("cmd_grant", 64'(w_grant), 64'(exp_grant));
        end
      end
      if (w_addr_valid && w_mem_ready) begin
        beat_cnt++;
        if (exp_beat_q.size() == 0) check_eq("beat_extra", 64'(exp_beat_q.size()), 64'd1);
        else begin
          eb = exp_beat_q.pop_front();
          check_eq("beat_addr", 64'(w_addr), 64'(eb));
        end
      end
      if (w_done) done_cnt++;
    end
  end

  // ---------------- input drivers ----------------
  initial begin
    int          cyc_ctr;
    bit          gate;
    logic [39:0] hd;
    cyc_ctr = 0;
    forever begin
      @(posedge w_clock);
      #1;
      cyc_ctr++;
      case (bp_mode)
        0: begin w_cmd_ready = 1'b1; w_mem_ready = 1'b1; gate = 1; end
        1: begin
          w_cmd_ready = ($urandom_range(0, 3) != 0);
          w_mem_ready = ($urandom_range(0, 2) != 0);
          gate        = ($urandom_range(0, 3) != 0);
        end
        default: begin
          // command stalls 3 of 4 cycles, beats accepted every other cycle,
          // FIFO empty 2 of 3 cycles
          w_cmd_ready = ((cyc_ctr % 4) == 3);
          w_mem_ready = ~w_mem_ready;
          gate        = ((cyc_ctr % 3) == 2);
        end
      endcase
      if (cfg_q.size() != 0 && gate) begin
        hd          = cfg_q[0];
        w_cfg_valid = 1'b1;
        w_cfg_addr  = hd[31:0];
        w_cfg_burst = hd[37:32];
      end else begin
        w_cfg_valid = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Picks the next core by rotating priority, decides mode from the core's
  // load state, and expands the config entries into commands and beats.
  task automatic plan_txn(input logic [NC-1:0] mask, input bit given);
    int            nst;
    bit            rd;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    m_sel = -1;
    for (int i = 0; i < NC; i++) begin
      int c;
      c = (m_ptr + i) % NC;
      if (m_sel < 0 && mask[c]) m_sel = c;
    end
    rd  = !m_load[m_sel];
    nst = rd ? NRS : 1;
    for (int s = 0; s < nst; s++) begin
      if (given) begin
        a = g_addr[s];
        b = g_burst[s];
      end else begin
        a = $urandom;
        b = BW'($urandom_range(0, 7));
      end
      cfg_q.push_back({2'(s), b, a});
      if (b != 0) begin
        exp_q.push_back({rd, b, a});
        for (int k = 0; k < int'(b); k++) exp_beat_q.push_back(a + AW'(k));
      end
    end
    exp_grant = NC'(1) << m_sel;
  endtask

  // Called just after a rising edge; returns just after the edge that ends DONE.
  task automatic do_txn(input logic [NC-1:0] mask, input bit given);
    int start;
    int cyc;
    plan_txn(mask, given);
    w_req = mask;
    start = done_cnt;
    cyc   = 0;
    while (done_cnt == start && cyc < 3000) begin
      @(posedge w_clock);
      #2;
      cyc++;
    end
    check_eq("done_seen", 64'(done_cnt - start), 64'd1);
    if (done_cnt == start) report_and_finish();
    last_cyc = cyc;
    m_load[m_sel] = ~m_load[m_sel];
    m_ptr = (m_sel + 1) % NC;
    n_txn++;
    grant_log.push_back(obs_grant);
    check_eq("cmd_q_drained", 64'(exp_q.size()), 64'd0);
    check_eq("beat_q_drained", 64'(exp_beat_q.size()), 64'd0);
    check_eq("cfg_q_drained", 64'(cfg_q.size()), 64'd0);
    check_eq("load_state", 64'(w_load), 64'(m_load));
  endtask

  task automatic check_rst_vals();
    check_eq("rst_cfg_ready", 64'(w_cfg_ready), 64'd0);
    check_eq("rst_cmd_valid", 64'(w_cmd_valid), 64'd0);
    check_eq("rst_cmd_rw", 64'(w_cmd_rw), 64'd0);
    check_eq("rst_cmd_burst", 64'(w_cmd_burst), 64'd0);
    check_eq("rst_addr_valid", 64'(w_addr_valid), 64'd0);
    check_eq("rst_addr", 64'(w_addr), 64'd0);
    check_eq("rst_stage", 64'(w_stage), 64'd0);
    check_eq("rst_done", 64'(w_done), 64'd0);
    check_eq("rst_grant", 64'(w_grant), 64'd0);
    check_eq("rst_load", 64'(w_load), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          b0;
    int          cyc;
    int          dsave;
    logic [NC-1:0] rr_exp[5];

    // reset: asserted between edges so only the asynchronous path can act
    #1 w_reset_n = 1'b0;
    #1 check_rst_vals();
    repeat (3) @(posedge w_clock);
    #2 w_reset_n = 1'b1;
    repeat (2) @(posedge w_clock);
    #2;
    check_eq("idle_cfg_ready", 64'(w_cfg_ready), 64'd0);
    check_eq("idle_grant", 64'(w_grant), 64'd0);

    // single read on core 0
    bp_mode = 0;
    g_addr[0] = 32'h100; g_burst[0] = 6'd4;
    g_addr[1] = 32'h200; g_burst[1] = 6'd2;
    g_addr[2] = 32'h300; g_burst[2] = 6'd3;
    b0 = beat_cnt;
    do_txn(4'b0001, 1);
    check_eq("read_beats", 64'(beat_cnt - b0), 64'd9);
    check_eq("read_load", 64'(w_load), 64'b0001);
    w_req = '0;

    // follow-up write on core 0, minimum latency B + 5 edges from request
    g_addr[0] = 32'h400; g_burst[0] = 6'd5;
    do_txn(4'b0001, 1);
    check_eq("write_latency", 64'(last_cyc), 64'd10);
    check_eq("write_load", 64'(w_load), 64'b0000);
    w_req = '0;

    // reset in the middle of a burst: at beat 2 of 8
    g_addr[0] = 32'h900; g_burst[0] = 6'd8;
    g_addr[1] = 32'hA00; g_burst[1] = 6'd2;
    g_addr[2] = 32'hB00; g_burst[2] = 6'd1;
    repeat (2) @(posedge w_clock);
    #2;
    plan_txn(4'b0001, 1);
    w_req = 4'b0001;
    b0  = beat_cnt;
    cyc = 0;
    while (beat_cnt - b0 < 2 && cyc < 200) begin
      @(posedge w_clock);
      #2;
      cyc++;
    end
    check_eq("mid_beat_reached", 64'(beat_cnt - b0), 64'd2);
    w_reset_n = 1'b0;
    #1 check_rst_vals();
    cfg_q.delete();
    exp_q.delete();
    exp_beat_q.delete();
    w_req  = '0;
    m_load = '0;
    m_ptr  = 0;
    dsave  = done_cnt;
    repeat (2) @(posedge w_clock);
    #2;
    check_eq("rst_hold_addr_valid", 64'(w_addr_valid), 64'd0);
    w_reset_n = 1'b1;
    repeat (3) @(posedge w_clock);
    #2;
    check_eq("post_rst_load", 64'(w_load), 64'd0);
    check_eq("post_rst_grant", 64'(w_grant), 64'd0);
    check_eq("post_rst_cfg_ready", 64'(w_cfg_ready), 64'd0);
    check_eq("post_rst_no_done", 64'(done_cnt - dsave), 64'd0);

    // round robin with random backpressure: each finished core drops its request
    bp_mode = 1;
    grant_log.delete();
    do_txn(4'b1111, 0);
    do_txn(4'b1110, 0);
    do_txn(4'b1101, 0);
    do_txn(4'b1011, 0);
    do_txn(4'b0111, 0);
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    for (int i = 0; i < 5; i++) check_eq("rr_order", 64'(grant_log[i]), 64'(rr_exp[i]));
    // all requests withdrawn while arbitrating: no grant follows
    w_req = '0;
    dsave = done_cnt;
    repeat (4) @(posedge w_clock);
    #2;
    check_eq("drop_grant", 64'(w_grant), 64'd0);
    check_eq("drop_cfg_ready", 64'(w_cfg_ready), 64'd0);
    check_eq("drop_no_done", 64'(done_cnt - dsave), 64'd0);

    // scripted backpressure on core 2 (write then read)
    bp_mode = 2;
    g_addr[0] = 32'h1000; g_burst[0] = 6'd5;
    g_addr[1] = 32'h2000; g_burst[1] = 6'd3;
    g_addr[2] = 32'h3000; g_burst[2] = 6'd4;
    do_txn(4'b0100, 1);
    w_req = '0;
    do_txn(4'b0100, 1);
    w_req = '0;

    // boundaries: address wrap, zero-length stage, zero-length write
    bp_mode = 0;
    g_addr[0] = 32'hFFFF_FFFE; g_burst[0] = 6'd4;
    do_txn(4'b0010, 1);
    w_req = '0;
    g_addr[0] = 32'h500; g_burst[0] = 6'd3;
    g_addr[1] = 32'h600; g_burst[1] = 6'd0;
    g_addr[2] = 32'h700; g_burst[2] = 6'd2;
    do_txn(4'b0010, 1);
    w_req = '0;
    g_addr[0] = 32'h800; g_burst[0] = 6'd0;
    b0 = beat_cnt;
    do_txn(4'b1000, 1);
    check_eq("zero_write_beats", 64'(beat_cnt - b0), 64'd0);
    w_req = '0;

    // randomized traffic
    bp_mode = 1;
    for (int t = 0; t < 25; t++) begin
      do_txn(NC'($urandom_range(1, 15)), 0);
    end
    w_req = '0;
    repeat (4) @(posedge w_clock);
    #2;
    check_eq("done_total", 64'(done_cnt), 64'(n_txn));
    report_and_finish();
  end

endmodule
